fifo_wr_arbiter: RTL

Shares one write port of the synchronous FIFO (DEPTH 16, WIDTH 8) among NREQ producers with round-robin arbitration and bounded bursts. Tracks FIFO occupancy internally as a credit count, so it never issues a write into a full FIFO. Sits directly in front of the FIFO, driving its wr_en and wr_data, and observes the consumer's rd_en and the FIFO's empty and full flags.

---
 rtl/fifo_wr_arbiter_pkg.sv | 16 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 39 +++
 rtl/fifo_wr_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared defaults and state encoding for the FIFO write-port arbiter.
// The top and the round-robin picker both import this package.
package fifo_arb_defs;

    localparam int DEF_DEPTH     = 16;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_PTR_WIDTH = 4;
    localparam int DEF_NREQ      = 4;
    localparam int DEF_MAX_BURST = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NREQ.
module rr_pick
    import fifo_arb_defs::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = $clog2(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    // Candidate index for each scan position, rotated so position 0 is ptr.
    logic [IW-1:0] cand [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand[gi] = IW'((int'(ptr) + gi) % NREQ);
        end
    endgenerate

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req[cand[k]]) begin
                any          = 1'b1;
                idx          = cand[k];
                grant[cand[k]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among NREQ
// producers; a local credit count guarantees no write lands in a full FIFO.
module fifo_wr_arbiter
    import fifo_arb_defs::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int PTR_WIDTH = DEF_PTR_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       ack,
    output logic                  fifo_wr_en,
    output logic [WIDTH-1:0]      fifo_wr_data,
    input  logic                  fifo_rd_en,
    input  logic                  fifo_empty,
    input  logic                  fifo_full,
    output logic [PTR_WIDTH:0]    count,
    output logic                  ovf_err
);

    localparam int IW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [PTR_WIDTH:0] FULL_CNT   = (PTR_WIDTH + 1)'(DEPTH);
    localparam logic [BW-1:0]      BURST_LAST = BW'(MAX_BURST);

    arb_state_t         state_reg, state_next;
    logic [IW-1:0]      ptr_reg, ptr_next;
    logic [IW-1:0]      owner_reg, owner_next;
    logic [BW-1:0]      burst_cnt_reg, burst_cnt_next;
    logic [PTR_WIDTH:0] count_reg;
    logic               wr_en_reg;
    logic [WIDTH-1:0]   wr_data_reg;
    logic               ovf_reg;

    logic [NREQ-1:0]    pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               credit;
    logic               xfer;
    logic               rd_fire;
    logic [IW-1:0]      sel;
    logic [WIDTH-1:0]   data_arr [NREQ];

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_data
            assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // A read only frees a credit once it has been counted at an edge.
    assign credit  = count_reg < FULL_CNT;
    assign rd_fire = fifo_rd_en && !fifo_empty;
    assign sel     = (state_reg == IDLE) ? pick_idx : owner_reg;
    assign xfer    = |(req & ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            owner_reg     <= '0;
            burst_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            owner_reg     <= owner_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        owner_next     = owner_reg;
        burst_cnt_next = burst_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (xfer) begin
                    owner_next     = pick_idx;
                    burst_cnt_next = BW'(1);
                    if (MAX_BURST == 1) begin
                        ptr_next = next_idx(pick_idx);
                    end else begin
                        state_next = BURST;
                    end
                end
            end
            BURST: begin
                if (!req[owner_reg]) begin
                    state_next = IDLE;
                    ptr_next   = next_idx(owner_reg);
                end else if (xfer) begin
                    burst_cnt_next = burst_cnt_reg + 1'b1;
                    if (burst_cnt_next == BURST_LAST) begin
                        state_next = IDLE;
                        ptr_next   = next_idx(owner_reg);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ack = '0;
        if (!rst && credit) begin
            if (state_reg == IDLE) begin
                ack = pick_any ? pick_grant : '0;
            end else begin
                ack[owner_reg] = req[owner_reg];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg   <= '0;
            wr_en_reg   <= 1'b0;
            wr_data_reg <= '0;
            ovf_reg     <= 1'b0;
        end else begin
            case ({xfer, rd_fire})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            wr_en_reg <= xfer;
            if (xfer) begin
                wr_data_reg <= data_arr[sel];
            end
            if (wr_en_reg && fifo_full) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign fifo_wr_en   = wr_en_reg;
    assign fifo_wr_data = wr_data_reg;
    assign count        = count_reg;
    assign ovf_err      = ovf_reg;

endmodule
